reg_dump_sequencer: RTL and testbench

Debug sequencer that reads all general-purpose registers out of the decode-stage register bank once the processor is halted and streams them as bytes to the debug UART transmitter. It drives the bank's debug read address and the debug/instruction select of the port-A address mux. It captures port-A read data and serialises each 32-bit word MSB-first over a valid/ready byte interface.

---
 rtl/reg_dump_sequencer_if.sv | 35 +++
 rtl/reg_dump_sequencer.sv | 122 ++++++++++++
 tb/tb_reg_dump_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_sequencer_if.sv
// Register-bank debug port plus byte stream towards the debug UART transmitter.
// Latency: none, wires only.
// Backpressure: tx_ready_i from the transmitter stalls the byte stream.
interface reg_dump_sequencer_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
);
  logic [NB_DATA-1:0] data_ra_i;
  logic               select_debug_o;
  logic [NB_REG-1:0]  addr_reg_debug_o;
  logic [NB_BYTE-1:0] tx_data_o;
  logic               tx_valid_o;
  logic               tx_ready_i;

  // Sequencer side: drives the bank address/select and the byte stream.
  modport master (
    input  data_ra_i,
    input  tx_ready_i,
    output select_debug_o,
    output addr_reg_debug_o,
    output tx_data_o,
    output tx_valid_o
  );

  // Bank/transmitter side.
  modport slave (
    output data_ra_i,
    output tx_ready_i,
    input  select_debug_o,
    input  addr_reg_debug_o,
    input  tx_data_o,
    input  tx_valid_o
  );
endinterface

// File: rtl/reg_dump_sequencer.sv
// Dumps every general-purpose register of the halted core as MSB-first bytes.
// Latency: first byte valid 3 cycles after start; 2 + NB_DATA/NB_BYTE cycles per register.
// Backpressure: tx_ready_i low holds the current byte stable indefinitely.
module reg_dump_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  reg_dump_sequencer_if.master bus,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(N_BYTES - 1);
  localparam logic [NB_REG-1:0] CNT_LAST = NB_REG'(N_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LATCH,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [NB_REG-1:0]  cnt, cnt_nxt;
  logic [NB_IDX-1:0]  idx, idx_nxt;
  logic [NB_DATA-1:0] word, word_nxt;
  logic [NB_DATA-1:0] word_shifted;

  logic               sel_dbg;
  logic [NB_REG-1:0]  addr_dbg;
  logic [NB_BYTE-1:0] tx_dat;
  logic               tx_vld;

  // Byte index 0 is the most significant byte of the captured word.
  assign word_shifted = word >> ((N_BYTES - 1 - int'(idx)) * NB_BYTE);

  // State and datapath registers; reset abandons any in-flight byte.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      word  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      word  <= word_nxt;
    end
  end

  // Next-state logic; outputs decode state/registers only, never tx_ready_i or start_i.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    word_nxt  = word;
    sel_dbg   = 1'b0;
    addr_dbg  = '0;
    tx_dat    = '0;
    tx_vld    = 1'b0;
    busy_o    = (state != ST_IDLE);
    done_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = ST_SELECT;
          cnt_nxt   = '0;
        end
      end
      ST_SELECT: begin
        sel_dbg   = 1'b1;
        addr_dbg  = cnt;
        state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        sel_dbg   = 1'b1;
        addr_dbg  = cnt;
        word_nxt  = bus.data_ra_i;
        idx_nxt   = '0;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        // Address keeps its last value; the mux ignores it while deselected.
        addr_dbg = cnt;
        tx_vld   = 1'b1;
        tx_dat   = word_shifted[NB_BYTE-1:0];
        if (bus.tx_ready_i) begin
          if (idx != IDX_LAST) begin
            idx_nxt = idx + 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = ST_SELECT;
          end
        end
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.select_debug_o   = sel_dbg;
  assign bus.addr_reg_debug_o = addr_dbg;
  assign bus.tx_data_o        = tx_dat;
  assign bus.tx_valid_o       = tx_vld;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench for reg_dump_sequencer with a register-bank model.
// Latency: expected done cycle derived from the per-register cycle budget.
// Backpressure: random 30% tx_ready duty in one phase, otherwise always ready.
module tb_reg_dump_sequencer;
  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int N_REGS  = 32;
  localparam int NB_BYTE = 8;
  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int CYC_PER_REG = 2 + N_BYTES;

  typedef struct {
    bit timed;
    int done_cyc;
  } dump_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic bp = 1'b0;
  logic busy, done;
  int   cyc = 0;

  logic [NB_DATA-1:0] bank [N_REGS];
  logic [NB_BYTE-1:0] exp_bytes [$];
  dump_t              exp_dump [$];

  int tests = 0;
  int fails = 0;

  // monitor state
  int sel_cnt = 0;
  int busy_cnt = 0;
  bit prev_stall = 0;
  logic [NB_BYTE-1:0] prev_data = '0;

  reg_dump_sequencer_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) bus ();

  reg_dump_sequencer #(
    .NB_DATA(NB_DATA), .NB_REG(NB_REG), .N_REGS(N_REGS), .NB_BYTE(NB_BYTE)
  ) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .start_i (start),
    .bus     (bus.master),
    .busy_o  (busy),
    .done_o  (done)
  );

  // Bank model: debug address reads the bank, otherwise the instruction path shows junk.
  assign bus.data_ra_i  = bus.select_debug_o ? bank[bus.addr_reg_debug_o] : 32'hDEAD_BEEF;
  assign bus.tx_ready_i = ready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter ready: 30% duty under backpressure, else always ready.
  always @(posedge clk) begin
    #2;
    ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none (t=%0t)", name, $time);
  endtask

  // Reference stream: every register, bytes most significant first.
  task automatic issue_dump(input bit timed);
    dump_t d;
    for (int r = 0; r < N_REGS; r++)
      for (int b = 0; b < N_BYTES; b++)
        exp_bytes.push_back(NB_BYTE'(bank[r] >> ((N_BYTES - 1 - b) * NB_BYTE)));
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    d.timed = timed;
    // Start sampled at edge cyc; SELECT follows immediately and DONE is the
    // interval after the last of N_REGS register slots.
    d.done_cyc = cyc + N_REGS * CYC_PER_REG;
    exp_dump.push_back(d);
  endtask

  task automatic wait_dump_done();
    for (int i = 0; i < 4000 && exp_dump.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_dump.size() != 0) begin
      fail_now("dump_timeout");
      exp_dump.delete();
      exp_bytes.delete();
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic fill_random();
    for (int r = 0; r < N_REGS; r++) bank[r] = $urandom;
  endtask

  // Monitor: pops expected bytes on each transfer and closes a dump on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      sel_cnt = 0;
      busy_cnt = 0;
      prev_stall = 0;
    end else begin
      if (bus.select_debug_o) begin
        check("addr_seq", bus.addr_reg_debug_o, sel_cnt / 2);
        sel_cnt++;
      end
      if (busy) busy_cnt++;
      if (prev_stall) begin
        check("hold_valid", bus.tx_valid_o, 1);
        check("hold_data", bus.tx_data_o, prev_data);
      end
      prev_stall = bus.tx_valid_o && !ready;
      prev_data  = bus.tx_data_o;
      if (bus.tx_valid_o && ready) begin
        if (exp_bytes.size() == 0) fail_now("extra_byte");
        else check("byte", bus.tx_data_o, exp_bytes.pop_front());
      end
      if (done) begin
        if (exp_dump.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          dump_t d;
          d = exp_dump.pop_front();
          check("bytes_left", exp_bytes.size(), 0);
          check("select_cycles", sel_cnt, 2 * N_REGS);
          if (d.timed) begin
            check("done_cycle", cyc, d.done_cyc);
            check("busy_cycles", busy_cnt, 1 + N_REGS * CYC_PER_REG);
          end
        end
        sel_cnt = 0;
        busy_cnt = 0;
      end
    end
  end

  initial begin
    int ks;
    for (int r = 0; r < N_REGS; r++) bank[r] = '0;

    // Reset, then idle with no start.
    repeat (3) @(posedge clk);
    #2;
    check("in_reset_outs", {bus.select_debug_o, bus.addr_reg_debug_o, bus.tx_data_o,
                            bus.tx_valid_o, busy, done}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outs", {bus.select_debug_o, bus.addr_reg_debug_o, bus.tx_data_o,
                          bus.tx_valid_o, busy, done}, 0);
    end
    @(posedge clk);
    #2;

    // Full dump of a patterned bank, always ready.
    for (int r = 0; r < N_REGS; r++) bank[r] = 32'hA500_0000 + r;
    issue_dump(1'b1);
    wait_dump_done();

    // Random bank under backpressure.
    fill_random();
    bp = 1'b1;
    issue_dump(1'b0);
    wait_dump_done();
    bp = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Start pulse during SEND of register 5 must be ignored.
    fill_random();
    issue_dump(1'b1);
    ks = cyc;
    repeat (5 * CYC_PER_REG + 2) @(posedge clk);
    #2;
    check("send_r5_valid", bus.tx_valid_o, 1);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_dump_done();
    repeat (20) @(posedge clk);
    #2;
    check("idle_after_ignored_start", busy, 0);

    // Reset while register 10 byte 2 is on the bus.
    fill_random();
    issue_dump(1'b1);
    ks = cyc;
    repeat (10 * CYC_PER_REG + 2 + 2) @(posedge clk);
    #2;
    check("r10b2_valid", bus.tx_valid_o, 1);
    check("r10b2_data", bus.tx_data_o, NB_BYTE'(bank[10] >> (1 * NB_BYTE)));
    rst_n = 1'b0;
    exp_bytes.delete();
    exp_dump.delete();
    #1;
    check("async_reset_outs", {bus.select_debug_o, bus.addr_reg_debug_o, bus.tx_data_o,
                               bus.tx_valid_o, busy, done}, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Restart after reset begins at register 0, byte 0.
    fill_random();
    issue_dump(1'b1);
    wait_dump_done();
    repeat (10) @(posedge clk);
    #2;
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
